rpsc_fault_latch_card: RTL and testbench
========================================

# rpsc_fault_latch_card

Parametrised fault-latch card for the RPSC protection rack, generalising the fixed eight-input fault cards. Raw, asynchronous, active-high fault inputs are synchronised and debounced per channel. The block drives live filtered fault outputs on selected channels and sticky latched-annunciator (LA) outputs on all channels. It also records which channel faulted first and accepts a latch-clear request from the reset card.

## Interface
- N_CH, 8, number of fault channels (2..32)
- FILT_CYCLES, 16, consecutive agreeing synchronised samples needed to change a filtered state (1..1023)
- OUT_MASK, N_CH'h0F, bit i=1 makes channel i drive its live fault_out bit; masked bits read 0
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous active-high latch-clear request from the reset card, level-sampled each cycle
- fault_in  in  N_CH  raw fault inputs, asynchronous, active-high
- fault_out  out  N_CH  filtered live fault state ANDed with OUT_MASK
- fault_la  out  N_CH  latched (sticky) fault per channel
- any_fault_la  out  1  OR of fault_la
- first_fault_valid  out  1  first-fault record is held
- first_fault_idx  out  $clog2(N_CH)  index of the first channel to latch

## Operation
- Synchroniser: two flops per channel on fault_in, giving sync[i].
- Debounce: each channel has a registered filt[i] and a counter cnt[i] of width $clog2(FILT_CYCLES+1).
  - If sync[i]==filt[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments. When the increment would reach FILT_CYCLES, filt[i] toggles and cnt[i] is set to 0.
  - The counter never wraps. Both assertion and deassertion are filtered symmetrically.
- fault_out[i] = filt[i] & OUT_MASK[i], taken directly from a register with no logic after the flop beyond the mask AND.
- Latch: la[i] is set on any cycle where filt[i]=1.
  - clear clears la[i] only if filt[i]=0 in that cycle.
  - Set dominates clear. A fault that is still active cannot be cleared.
- any_fault_la is the registered OR of the next-state la values, so it changes on the same edge as fault_la.
- First-fault capture (see Configuration):
  - Condition: first_fault_valid=0 and at least one la bit goes 0->1 on this edge.
  - Action: first_fault_valid is set, and first_fault_idx takes the lowest index among the bits newly set on this edge.
  - While first_fault_valid=1, later faults do not change the record.
  - clear resets first_fault_valid and first_fault_idx to 0 only when every la bit is 0 after that clear cycle. Otherwise the record is retained.
- Reset (asynchronous assert, any time including mid-filter): synchronisers, filt, cnt, la, first-fault record and every output go to 0. After release the block starts from the all-clear state. A fault still present is re-filtered from scratch, taking the full latency.

## Timing
- Let edge 0 be the first clk edge that samples fault_in=1.
- sync[i]=1 after edge 1.
- filt[i] and fault_out[i] assert after edge 1+FILT_CYCLES (input held high throughout).
- fault_la[i], any_fault_la and the first-fault record update after edge 2+FILT_CYCLES.
- Deassertion follows the same filter latency. fault_la stays set until a clear cycle with filt[i]=0.
- Pulses shorter than FILT_CYCLES sampled cycles never reach filt.
- Glitches reset the count: a single disagreeing sample restarts the qualification.
- clear takes effect on the edge that samples it, with no extra pipeline stage.
- If clear and a new latch set fall on the same edge, the set wins for that channel, and that channel keeps the first-fault record valid.

## Configuration
- RPSC_FIRST_FAULT_EN defined:
  - The first-fault capture logic is built as described above.
- RPSC_FIRST_FAULT_EN undefined:
  - No first-fault registers are built.
  - first_fault_valid and first_fault_idx are tied to 0.
  - All other behaviour is identical.

## Test plan
All scenarios use N_CH=8, FILT_CYCLES=4, OUT_MASK=8'h0F.
- Debounce reject: fault_in[1] high for 3 cycles, then low -> fault_out, fault_la and any_fault_la remain 0 throughout.
- Debounce accept: fault_in[1] held high from edge 0 -> fault_out=8'h02 after edge 5; fault_la=8'h02, any_fault_la=1, first_fault_idx=1, first_fault_valid=1 after edge 6.
- Mask and first fault:
  - Stimulus: fault_in[5] and fault_in[2] asserted on the same edge, then fault_in[0] asserted 10 cycles later.
  - Response: fault_out=8'h04, then 8'h05 (bit 5 masked off); fault_la=8'h24, then 8'h25; first_fault_idx=2 throughout.
- Clear rules:
  - Stimulus: clear pulsed while fault_in[2] is still high.
  - Response: fault_la unchanged and the record retained.
  - Stimulus: drop fault_in[2], wait 6 cycles, pulse clear.
  - Response: fault_la=8'h00, any_fault_la=0, first_fault_valid=0 on that edge.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously two cycles into a filter count with latches set.
  - Response: all outputs 0 immediately. After release with the input still high, fault_out re-asserts exactly 1+FILT_CYCLES edges later.
- Macro off: rebuild without RPSC_FIRST_FAULT_EN and repeat the accept scenario -> identical fault_out/fault_la timing; first_fault_valid and first_fault_idx stay 0.

Source files
------------

// File: rtl/rpsc_fault_latch_card_if.sv
// rpsc_fault_latch_card_if
// Bundles the fault-card signals exchanged with the rack: the latch-clear
// request and raw fault inputs, plus the live, latched and first-fault outputs.
// The card itself connects through the slave modport; the rack side (or a bench)
// uses master.
interface rpsc_fault_latch_card_if #(
  parameter int N_CH = 8
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             clear;
  logic [N_CH-1:0]  fault_in;
  logic [N_CH-1:0]  fault_out;
  logic [N_CH-1:0]  fault_la;
  logic             any_fault_la;
  logic             first_fault_valid;
  logic [IDX_W-1:0] first_fault_idx;

  modport master (
    output clear,
    output fault_in,
    input  fault_out,
    input  fault_la,
    input  any_fault_la,
    input  first_fault_valid,
    input  first_fault_idx
  );

  modport slave (
    input  clear,
    input  fault_in,
    output fault_out,
    output fault_la,
    output any_fault_la,
    output first_fault_valid,
    output first_fault_idx
  );
endinterface

// File: rtl/rpsc_fault_latch_card.sv
// rpsc_fault_latch_card
// Per-channel synchroniser, symmetric debounce filter and sticky latch for the
// RPSC protection rack. A fault that is still filtered active cannot be
// cleared. Live outputs are gated by OUT_MASK.
// Optional feature macro: RPSC_FIRST_FAULT_EN builds the first-fault recorder;
// without it first_fault_valid/first_fault_idx are tied to 0.
module rpsc_fault_latch_card #(
  parameter int              N_CH        = 8,
  parameter int              FILT_CYCLES = 16,
  parameter logic [N_CH-1:0] OUT_MASK    = N_CH'('h0F)
) (
  input logic                   clk,
  input logic                   reset_n,
  rpsc_fault_latch_card_if.slave bus
);
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] r_meta;
  logic [N_CH-1:0] r_sync;
  logic [N_CH-1:0] w_filt;
  logic [N_CH-1:0] r_la;
  logic [N_CH-1:0] w_la_next;
  logic            r_any;

  // Two-flop synchroniser on the raw asynchronous fault inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= bus.fault_in;
      r_sync <= r_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_filt;
      logic [CNT_W:0]   w_cnt_inc;

      // One extra bit so the compare against FILT_CYCLES never sees a wrap
      assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

      // Debounce: count consecutive disagreeing samples, toggle on reaching FILT_CYCLES
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_sync[gi] == r_filt) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == (CNT_W + 1)'(FILT_CYCLES)) begin
          r_filt <= ~r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
      end

      assign w_filt[gi] = r_filt;
      // Set dominates clear: an active filtered fault keeps its latch
      assign w_la_next[gi] = r_filt | (r_la[gi] & ~bus.clear);
    end
  endgenerate

  // Sticky latches and their OR, both updated from the same next-state value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_la  <= '0;
      r_any <= 1'b0;
    end else begin
      r_la  <= w_la_next;
      r_any <= |w_la_next;
    end
  end

  assign bus.fault_out    = w_filt & OUT_MASK;
  assign bus.fault_la     = r_la;
  assign bus.any_fault_la = r_any;

`ifdef RPSC_FIRST_FAULT_EN
  logic [N_CH-1:0]  w_new_la;
  logic [IDX_W-1:0] w_low_idx;
  logic             r_ff_valid;
  logic [IDX_W-1:0] r_ff_idx;

  assign w_new_la = w_la_next & ~r_la;

  // Lowest index among latches rising on this edge (scan high to low, last hit wins)
  always_comb begin
    w_low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_new_la[i]) w_low_idx = IDX_W'(i);
    end
  end

  // First-fault record: capture once, release only when clear empties every latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (!r_ff_valid && (|w_new_la)) begin
      r_ff_valid <= 1'b1;
      r_ff_idx   <= w_low_idx;
    end else if (bus.clear && (w_la_next == '0)) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end
  end

  assign bus.first_fault_valid = r_ff_valid;
  assign bus.first_fault_idx   = r_ff_idx;
`else
  assign bus.first_fault_valid = 1'b0;
  assign bus.first_fault_idx   = '0;
`endif

endmodule

// File: tb/tb_rpsc_fault_latch_card.sv
// tb_rpsc_fault_latch_card
// Directed bench for N_CH=8, FILT_CYCLES=4, OUT_MASK=8'h0F. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
// First-fault expectations follow RPSC_FIRST_FAULT_EN (tied to 0 when undefined).
module tb_rpsc_fault_latch_card;
  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  rpsc_fault_latch_card_if #(.N_CH(8)) bus ();

  rpsc_fault_latch_card #(
    .N_CH(8),
    .FILT_CYCLES(4),
    .OUT_MASK(8'h0F)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic chk_ff(input logic v, input int idx);
`ifdef RPSC_FIRST_FAULT_EN
    chk("ff_valid", 32'(bus.first_fault_valid), 32'(v));
    chk("ff_idx", 32'(bus.first_fault_idx), 32'(idx));
`else
    chk("ff_valid", 32'(bus.first_fault_valid), 32'(1'b0));
    chk("ff_idx", 32'(bus.first_fault_idx), 32'(0) + 32'(idx) * 0);
`endif
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.clear    = 1'b0;
    bus.fault_in = 8'h00;
    repeat (3) cyc();
    chk("rst_out", 32'(bus.fault_out), 32'h00);
    chk("rst_la", 32'(bus.fault_la), 32'h00);
    chk("rst_any", 32'(bus.any_fault_la), 32'h0);
    chk_ff(1'b0, 0);
    reset_n = 1'b1;
    repeat (3) cyc();

    // Debounce reject: 3-cycle pulse on channel 1
    bus.fault_in = 8'h02;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.fault_in = 8'h00;
      cyc();
      chk("rej_out", 32'(bus.fault_out), 32'h00);
      chk("rej_la", 32'(bus.fault_la), 32'h00);
      chk("rej_any", 32'(bus.any_fault_la), 32'h0);
    end

    // Debounce accept on channel 1
    bus.fault_in = 8'h02;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("acc_out_early", 32'(bus.fault_out), 32'h00);
    end
    cyc();
    chk("acc_out_e5", 32'(bus.fault_out), 32'h02);
    chk("acc_la_e5", 32'(bus.fault_la), 32'h00);
    cyc();
    chk("acc_la_e6", 32'(bus.fault_la), 32'h02);
    chk("acc_any_e6", 32'(bus.any_fault_la), 32'h1);
    chk_ff(1'b1, 1);
    bus.fault_in = 8'h00;
    repeat (6) cyc();
    chk("acc_out_off", 32'(bus.fault_out), 32'h00);
    chk("acc_la_sticky", 32'(bus.fault_la), 32'h02);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("acc_clr_la", 32'(bus.fault_la), 32'h00);
    chk("acc_clr_any", 32'(bus.any_fault_la), 32'h0);
    chk_ff(1'b0, 0);

    // Mask and first fault: channels 5 and 2 together, channel 0 ten cycles later
    bus.fault_in = 8'h24;
    repeat (5) cyc();
    chk("msk_out_e4", 32'(bus.fault_out), 32'h00);
    cyc();
    chk("msk_out_e5", 32'(bus.fault_out), 32'h04);
    chk("msk_la_e5", 32'(bus.fault_la), 32'h00);
    cyc();
    chk("msk_la_e6", 32'(bus.fault_la), 32'h24);
    chk_ff(1'b1, 2);
    repeat (3) cyc();
    bus.fault_in = 8'h25;
    repeat (5) cyc();
    chk("msk_out_e14", 32'(bus.fault_out), 32'h04);
    cyc();
    chk("msk_out_e15", 32'(bus.fault_out), 32'h05);
    cyc();
    chk("msk_la_e16", 32'(bus.fault_la), 32'h25);
    chk("msk_any_e16", 32'(bus.any_fault_la), 32'h1);
    chk_ff(1'b1, 2);

    // Clear while every latched channel is still active: nothing changes
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clr_active_la", 32'(bus.fault_la), 32'h25);
    chk_ff(1'b1, 2);

    // Drop channels 5 and 0, clear with channel 2 still active
    bus.fault_in = 8'h04;
    repeat (6) cyc();
    chk("clr_part_out", 32'(bus.fault_out), 32'h04);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clr_part_la", 32'(bus.fault_la), 32'h04);
    chk("clr_part_any", 32'(bus.any_fault_la), 32'h1);
    chk_ff(1'b1, 2);

    // Drop channel 2, wait 6 cycles, clear everything
    bus.fault_in = 8'h00;
    repeat (6) cyc();
    chk("clr_full_out", 32'(bus.fault_out), 32'h00);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clr_full_la", 32'(bus.fault_la), 32'h00);
    chk("clr_full_any", 32'(bus.any_fault_la), 32'h0);
    chk_ff(1'b0, 0);

    // Clear on the same edge as a new latch set on channel 3: set wins
    bus.fault_in = 8'h08;
    repeat (6) cyc();
    chk("same_out", 32'(bus.fault_out), 32'h08);
    chk("same_la_pre", 32'(bus.fault_la), 32'h00);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("same_la", 32'(bus.fault_la), 32'h08);
    chk("same_any", 32'(bus.any_fault_la), 32'h1);
    chk_ff(1'b1, 3);

    // Reset two cycles into channel 1's filter count with channel 3 latched
    bus.fault_in = 8'h0A;
    repeat (4) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("rstm_out", 32'(bus.fault_out), 32'h00);
    chk("rstm_la", 32'(bus.fault_la), 32'h00);
    chk("rstm_any", 32'(bus.any_fault_la), 32'h0);
    chk_ff(1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rstm_out_early", 32'(bus.fault_out), 32'h00);
    end
    cyc();
    chk("rstm_out_e5", 32'(bus.fault_out), 32'h0A);
    chk("rstm_la_e5", 32'(bus.fault_la), 32'h00);
    cyc();
    chk("rstm_la_e6", 32'(bus.fault_la), 32'h0A);
    chk("rstm_any_e6", 32'(bus.any_fault_la), 32'h1);
    chk_ff(1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
